// File: rtl/led_pwm_seq.sv
// Multi-channel LED sequencer and PWM generator with OFF/STATIC/COUNT/BREATHE display modes.
// Levels and mode are shadowed at the PWM wrap so no PWM period is ever cut short.
`timescale 1ns/1ps
module led_pwm_seq #(
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned TICK_DIV = 48000
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         en_i,
    input  logic [1:0]                   mode_i,
    input  logic [15:0]                  period_i,
    input  logic [CHANNELS*PWM_BITS-1:0] duty_i,
    output logic [CHANNELS-1:0]          pwm_out_o,
    output logic                         step_pulse_o,
    output logic [CHANNELS-1:0]          seq_o
);

    localparam int unsigned TickW = $clog2(TICK_DIV);
    localparam int unsigned ProdW = 2 * PWM_BITS;
    localparam logic [TickW-1:0]    TickReload = TickW'(TICK_DIV - 1);
    localparam logic [PWM_BITS-1:0] PwmMax     = '1;

    typedef enum logic [1:0] {
        ModeOff     = 2'd0,
        ModeStatic  = 2'd1,
        ModeCount   = 2'd2,
        ModeBreathe = 2'd3
    } mode_e;

    logic [TickW-1:0]                   tick_cnt_q, tick_cnt_d;
    logic [15:0]                        step_cnt_q, step_cnt_d;
    logic [PWM_BITS-1:0]                pwm_cnt_q, pwm_cnt_d;
    logic [CHANNELS-1:0]                seq_q, seq_d;
    logic [PWM_BITS-1:0]                ramp_q, ramp_d;
    logic                               dir_q, dir_d;  // 1 = ramping down
    logic [CHANNELS-1:0][PWM_BITS-1:0]  level_q, level_d;
    mode_e                              cur_mode_q, cur_mode_d;
    logic [CHANNELS-1:0]                pwm_out_q, pwm_out_d;
    logic                               step_pulse_q, step_pulse_d;

    logic                               tick, wrap, step;
    logic [CHANNELS-1:0][PWM_BITS-1:0]  duty_ch;
    logic [CHANNELS-1:0][ProdW-1:0]     breathe_prod;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        assign duty_ch[g]      = duty_i[g*PWM_BITS +: PWM_BITS];
        assign breathe_prod[g] = ProdW'(duty_ch[g]) * ProdW'(ramp_q);
    end

    assign tick = en_i && (tick_cnt_q == '0);
    assign wrap = en_i && (pwm_cnt_q == PwmMax);
    assign step = en_i && step_pulse_q;

    always_comb begin
        tick_cnt_d   = tick_cnt_q;
        step_cnt_d   = step_cnt_q;
        pwm_cnt_d    = pwm_cnt_q;
        seq_d        = seq_q;
        ramp_d       = ramp_q;
        dir_d        = dir_q;
        level_d      = level_q;
        cur_mode_d   = cur_mode_q;
        pwm_out_d    = pwm_out_q;
        step_pulse_d = step_pulse_q;

        if (en_i) begin
            tick_cnt_d   = tick ? TickReload : tick_cnt_q - 1'b1;
            pwm_cnt_d    = pwm_cnt_q + 1'b1;
            step_pulse_d = 1'b0;
            if (tick) begin
                if (step_cnt_q == '0) begin
                    step_pulse_d = 1'b1;
                    step_cnt_d   = (period_i == '0) ? '0 : period_i - 16'd1;
                end else begin
                    step_cnt_d = step_cnt_q - 16'd1;
                end
            end
            for (int i = 0; i < CHANNELS; i++) begin
                pwm_out_d[i] = (level_q[i] == PwmMax) || (pwm_cnt_q < level_q[i]);
            end
        end

        if (step) begin
            unique case (cur_mode_q)
                ModeCount: seq_d = seq_q + 1'b1;
                ModeBreathe: begin
                    if (!dir_q) begin
                        ramp_d = ramp_q + 1'b1;
                        if (ramp_q == PwmMax - 1'b1) dir_d = 1'b1;
                    end else begin
                        ramp_d = ramp_q - 1'b1;
                        if (ramp_q == PWM_BITS'(1)) dir_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        if (wrap) begin
            // Levels use the mode/seq/ramp in force before this cycle's updates.
            for (int i = 0; i < CHANNELS; i++) begin
                unique case (cur_mode_q)
                    ModeOff:     level_d[i] = '0;
                    ModeStatic:  level_d[i] = duty_ch[i];
                    ModeCount:   level_d[i] = seq_q[i] ? duty_ch[i] : '0;
                    ModeBreathe: level_d[i] = breathe_prod[i][ProdW-1:PWM_BITS];
                    default:     level_d[i] = '0;
                endcase
            end
            // A mode change overrides any coincident step action.
            if (mode_e'(mode_i) != cur_mode_q) begin
                cur_mode_d = mode_e'(mode_i);
                seq_d      = '0;
                ramp_d     = '0;
                dir_d      = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tick_cnt_q   <= TickReload;
            step_cnt_q   <= '0;
            pwm_cnt_q    <= '0;
            seq_q        <= '0;
            ramp_q       <= '0;
            dir_q        <= 1'b0;
            level_q      <= '0;
            cur_mode_q   <= ModeOff;
            pwm_out_q    <= '0;
            step_pulse_q <= 1'b0;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            step_cnt_q   <= step_cnt_d;
            pwm_cnt_q    <= pwm_cnt_d;
            seq_q        <= seq_d;
            ramp_q       <= ramp_d;
            dir_q        <= dir_d;
            level_q      <= level_d;
            cur_mode_q   <= cur_mode_d;
            pwm_out_q    <= pwm_out_d;
            step_pulse_q <= step_pulse_d;
        end
    end

    assign pwm_out_o    = pwm_out_q;
    assign step_pulse_o = step_pulse_q && en_i;
    assign seq_o        = seq_q;

endmodule

// File: tb/tb_led_pwm_seq.sv
// Directed bench for led_pwm_seq (CHANNELS=3, PWM_BITS=4, TICK_DIV=4); cycle c counts from
// the cycle in which en rises, so pwm_cnt == c mod 16 and ticks land on c mod 4 == 3.
`timescale 1ns/1ps
module tb_led_pwm_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [1:0]  mode;
    logic [15:0] period;
    logic [11:0] duty;
    logic [2:0]  pwm_out;
    logic        step_pulse;
    logic [2:0]  seq;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    led_pwm_seq #(
        .CHANNELS (3),
        .PWM_BITS (4),
        .TICK_DIV (4)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (en),
        .mode_i       (mode),
        .period_i     (period),
        .duty_i       (duty),
        .pwm_out_o    (pwm_out),
        .step_pulse_o (step_pulse),
        .seq_o        (seq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Ramp value sampled at c201+4k during the breathe run.
    function automatic int ramp_exp(input int k);
        if (k <= 14) return k + 1;
        else if (k <= 29) return 29 - k;
        else return k - 29;
    endfunction

    logic [2:0] count_pwm [9];

    initial begin
        count_pwm = '{3'b111, 3'b111, 3'b010, 3'b010, 3'b100, 3'b100, 3'b110, 3'b110, 3'b000};
        rst_n  = 1'b0;
        en     = 1'b0;
        mode   = 2'd0;
        period = 16'd1;
        duty   = 12'h000;
        repeat (3) @(posedge clk);
        #1;

        // Reset mid-run
        rst_n = 1'b1; en = 1'b1; mode = 2'd1; duty = 12'hFFF; cyc = 0;
        wait_to(40);
        chk("run_pwm_all_on", pwm_out, 3'b111);
        rst_n = 1'b0;
        #1;
        chk("rst_pwm", pwm_out, 3'b000);
        chk("rst_step", step_pulse, 1'b0);
        chk("rst_seq", seq, 3'b000);
        chk("rst_tick_cnt", dut.tick_cnt_q, 3);
        en = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            chk("frz_pwm", pwm_out, 3'b000);
            chk("frz_step", step_pulse, 1'b0);
        end
        chk("frz_seq", seq, 3'b000);

        // STATIC, duty ch2=15 ch1=8 ch0=0; first wrap still latches OFF
        en = 1'b1; mode = 2'd1; duty = 12'hF80; period = 16'd1; cyc = 0;
        wait_to(32); chk("static_c32", pwm_out, 3'b000);
        wait_to(33); chk("static_c33", pwm_out, 3'b110);
        wait_to(40); chk("static_c40", pwm_out, 3'b110);
        wait_to(41); chk("static_c41", pwm_out, 3'b100);
        wait_to(48); chk("static_c48", pwm_out, 3'b100);
        wait_to(49); chk("static_c49", pwm_out, 3'b110);
        wait_to(50); duty = 12'hF40;
        wait_to(56); chk("duty_hold_c56", pwm_out, 3'b110);
        wait_to(65); chk("duty_new_c65", pwm_out, 3'b110);
        wait_to(68); chk("duty_new_c68", pwm_out, 3'b110);
        wait_to(69); chk("duty_new_c69", pwm_out, 3'b100);

        // COUNT, period=2
        mode = 2'd2; period = 16'd2; duty = 12'hFFF;
        wait_to(72); chk("cnt_step_c72", step_pulse, 1'b1);
        wait_to(73); chk("cnt_seq_static", seq, 3'd0);
        wait_to(79); chk("cnt_step_c79", step_pulse, 1'b0);
        wait_to(80); chk("cnt_step_c80", step_pulse, 1'b1);
        chk("cnt_cur_mode", dut.cur_mode_q, 2);
        for (int k = 0; k <= 8; k++) begin
            wait_to(81 + 8 * k);
            chk("cnt_seq", seq, (k + 1) % 8);
            chk("cnt_pwm", pwm_out, count_pwm[k]);
            if (k == 0) chk("cnt_step_c81", step_pulse, 1'b0);
        end

        // Mode switch COUNT->BREATHE with seq=5, requested mid-period
        period = 16'd3;
        wait_to(189); chk("sw_seq_before", seq, 3'd5);
        mode = 2'd3;
        wait_to(191); chk("sw_seq_pending", seq, 3'd5);
        wait_to(192);
        chk("sw_seq_clr", seq, 3'd0);
        chk("sw_cur_mode", dut.cur_mode_q, 3);
        chk("sw_ramp_clr", dut.ramp_q, 0);
        chk("sw_dir_up", dut.dir_q, 1'b0);
        chk("sw_pwm_c192", pwm_out, 3'b011);
        wait_to(193); chk("sw_pwm_c193", pwm_out, 3'b101);
        period = 16'd1;
        wait_to(201);
        chk("br_ramp_first", dut.ramp_q, 1);
        chk("br_dir_first", dut.dir_q, 1'b0);
        wait_to(208); chk("sw_pwm_c208", pwm_out, 3'b101);
        wait_to(209); chk("br_pwm_c209", pwm_out, 3'b111);
        wait_to(210); chk("br_pwm_c210", pwm_out, 3'b000);

        // BREATHE, period=1: ramp up to 15, down to 0, up again
        for (int k = 3; k <= 34; k++) begin
            wait_to(201 + 4 * k);
            chk("br_ramp", dut.ramp_q, ramp_exp(k));
            chk("br_dir", dut.dir_q, (k >= 14 && k < 29) ? 1 : 0);
            if (k % 4 == 2) chk("br_level0", dut.level_q[0], (15 * ramp_exp(k - 1)) >> 4);
        end

        // period=0 acts as 1; period 3->1 mid-count applies at next reload
        period = 16'd0;
        wait_to(340); chk("p0_c340", step_pulse, 1'b1);
        wait_to(341); chk("p0_c341", step_pulse, 1'b0);
        wait_to(343); chk("p0_c343", step_pulse, 1'b0);
        wait_to(344); chk("p0_c344", step_pulse, 1'b1);
        wait_to(345); period = 16'd3;
        wait_to(348); chk("p3_c348", step_pulse, 1'b1);
        wait_to(352); chk("p3_c352", step_pulse, 1'b0);
        period = 16'd1;
        wait_to(356); chk("p3_c356", step_pulse, 1'b0);
        wait_to(360); chk("p1_c360", step_pulse, 1'b1);
        wait_to(364); chk("p1_c364", step_pulse, 1'b1);

        // Freeze mid-run
        wait_to(365);
        chk("frz2_ramp_before", dut.ramp_q, 10);
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("frz2_step", step_pulse, 1'b0);
        end
        chk("frz2_ramp", dut.ramp_q, 10);
        chk("frz2_tick_cnt", dut.tick_cnt_q, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
